// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: display-stage state encoding, BCD digit width and
// the system clock rate from which cycle counts are derived.
package stopwatch_pkg;

  typedef enum logic {
    LIVE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int BCD_W  = 4;
  localparam int CLK_HZ = 5_000_000;

  // 10 ms debounce window and 3 s lap hold at the system clock rate
  localparam int DEBOUNCE_DEFAULT = CLK_HZ / 100;
  localparam int HOLD_DEFAULT     = CLK_HZ * 3;

endpackage

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchroniser, stability counter and a one-cycle
// pulse on each accepted 0->1 transition of the debounced level.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clock,
  input  logic reset,
  input  logic btn,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_p0;
  logic          sync_p1;
  logic          level;
  logic [CW-1:0] cnt;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      level   <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      sync_p0 <= btn;
      sync_p1 <= sync_p0;
      press   <= 1'b0;
      // a sample agreeing with the current level means the candidate change bounced
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync_p1;
        press <= sync_p1;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/lap_hold.sv
// Lap/split display stage: passes the live BCD count to the display, freezes it on a
// lap press for a fixed hold time, and keeps a BCD lap counter.
module lap_hold
  import stopwatch_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int HOLD_CYCLES     = HOLD_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             lap_btn,
  input  logic             run,
  input  logic [WIDTH-1:0] live_value,
  output logic [WIDTH-1:0] display_value,
  output logic             holding,
  output logic [BCD_W-1:0] lap_count
);

  localparam int TW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);

  function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(9)) ? '0 : d + BCD_W'(1);
  endfunction

  logic          lap_press;
  logic          capture;
  state_t        state;
  state_t        state_nx;
  logic [TW-1:0] timer;

  button_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_lap_debounce (
    .clock (clock),
    .reset (reset),
    .btn   (lap_btn),
    .press (lap_press)
  );

  always_comb begin
    state_nx = state;
    capture  = 1'b0;
    case (state)
      LIVE: begin
        if (lap_press && run) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        // a press on the expiry cycle wins over returning to live
        if (lap_press) begin
          capture = 1'b1;
        end else if (timer == '0) begin
          state_nx = LIVE;
        end
      end
      default: state_nx = LIVE;
    endcase
  end

  // The display register doubles as the hold register: it keeps its value while
  // holding and otherwise reloads from live_value.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= LIVE;
      timer         <= '0;
      lap_count     <= '0;
      holding       <= 1'b0;
      display_value <= '0;
    end else begin
      state   <= state_nx;
      holding <= (state_nx == HOLD);
      if (capture) begin
        timer     <= HOLD_LAST;
        lap_count <= bcd_inc(lap_count);
      end else if (state == HOLD && timer != '0) begin
        timer <= timer - TW'(1);
      end
      if (capture || state_nx == LIVE) begin
        display_value <= live_value;
      end
    end
  end

endmodule

// File: tb/tb_lap_hold.sv
// Directed bench for lap_hold with DEBOUNCE_CYCLES=4 and HOLD_CYCLES=20.
module tb_lap_hold;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        lap_btn = 1'b0;
  logic        run = 1'b0;
  logic [15:0] live_value = 16'h0000;
  logic [15:0] display_value;
  logic        holding;
  logic [3:0]  lap_count;

  int compared = 0;
  int mismatched = 0;
  logic [3:0] exp_cnt = 4'd0;

  lap_hold #(
    .WIDTH(16),
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES(20)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .lap_btn       (lap_btn),
    .run           (run),
    .live_value    (live_value),
    .display_value (display_value),
    .holding       (holding),
    .lap_count     (lap_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // n cycles with a ramping live value; expect either the held value or live tracking
  task automatic run_cycles(input int n, input logic [15:0] base,
                            input logic [15:0] held, input logic exp_hold);
    for (int i = 0; i < n; i++) begin
      live_value = base + 16'(i);
      step();
      chk("display", display_value, exp_hold ? held : base + 16'(i));
      chk("holding", {15'd0, holding}, {15'd0, exp_hold});
      chk("lap_count", {12'd0, lap_count}, {12'd0, exp_cnt});
    end
  endtask

  // clean press from LIVE with a full hold to expiry
  task automatic do_lap(input logic [15:0] cap, input logic [3:0] cnt_after);
    lap_btn = 1'b1;
    run_cycles(6, 16'h0119, 16'h0000, 1'b0);
    live_value = cap;
    exp_cnt = cnt_after;
    step();
    chk("cap_display", display_value, cap);
    chk("cap_holding", {15'd0, holding}, 16'd1);
    chk("cap_count", {12'd0, lap_count}, {12'd0, cnt_after});
    lap_btn = 1'b0;
    run_cycles(19, 16'h0500, cap, 1'b1);
    run_cycles(2, 16'h0600, 16'h0000, 1'b0);
  endtask

  initial begin
    step();
    step();
    chk("rst_display", display_value, 16'h0000);
    chk("rst_holding", {15'd0, holding}, 16'd0);
    chk("rst_count", {12'd0, lap_count}, 16'd0);
    reset = 1'b0;
    run = 1'b1;

    // live ramp tracks one cycle late
    run_cycles(49, 16'h0000, 16'h0000, 1'b0);

    // clean press captures 16'h0125
    do_lap(16'h0125, 4'd1);

    // bounce 1,0,1,0 then stable 1: one press, 6 cycles after the last edge
    lap_btn = 1'b1; run_cycles(1, 16'h0700, 16'h0000, 1'b0);
    lap_btn = 1'b0; run_cycles(1, 16'h0701, 16'h0000, 1'b0);
    lap_btn = 1'b1; run_cycles(1, 16'h0702, 16'h0000, 1'b0);
    lap_btn = 1'b0; run_cycles(1, 16'h0703, 16'h0000, 1'b0);
    lap_btn = 1'b1; run_cycles(6, 16'h0710, 16'h0000, 1'b0);
    live_value = 16'h0777;
    exp_cnt = 4'd2;
    step();
    chk("bounce_display", display_value, 16'h0777);
    chk("bounce_holding", {15'd0, holding}, 16'd1);
    chk("bounce_count", {12'd0, lap_count}, 16'd2);

    // second press mid-hold recaptures and reloads
    lap_btn = 1'b0; run_cycles(6, 16'h0800, 16'h0777, 1'b1);
    lap_btn = 1'b1; run_cycles(6, 16'h0810, 16'h0777, 1'b1);
    live_value = 16'h0210;
    exp_cnt = 4'd3;
    step();
    chk("recap_display", display_value, 16'h0210);
    chk("recap_count", {12'd0, lap_count}, 16'd3);

    // press landing on the expiry cycle keeps HOLD with the new value
    lap_btn = 1'b0; run_cycles(13, 16'h0900, 16'h0210, 1'b1);
    lap_btn = 1'b1; run_cycles(6, 16'h0920, 16'h0210, 1'b1);
    live_value = 16'h0333;
    exp_cnt = 4'd4;
    step();
    chk("tie_display", display_value, 16'h0333);
    chk("tie_holding", {15'd0, holding}, 16'd1);
    chk("tie_count", {12'd0, lap_count}, 16'd4);
    lap_btn = 1'b0;
    run_cycles(19, 16'h0a00, 16'h0333, 1'b1);
    run_cycles(2, 16'h0b00, 16'h0000, 1'b0);

    // press with run low is ignored
    run = 1'b0;
    lap_btn = 1'b1; run_cycles(10, 16'h0c00, 16'h0000, 1'b0);
    lap_btn = 1'b0; run_cycles(8, 16'h0c20, 16'h0000, 1'b0);
    run = 1'b1;

    // ten captures: 5..9, wrap to 0, 1..4
    do_lap(16'h1001, 4'd5);
    do_lap(16'h1002, 4'd6);
    do_lap(16'h1003, 4'd7);
    do_lap(16'h1004, 4'd8);
    do_lap(16'h1005, 4'd9);
    do_lap(16'h1006, 4'd0);
    do_lap(16'h1007, 4'd1);
    do_lap(16'h1008, 4'd2);
    do_lap(16'h1009, 4'd3);
    do_lap(16'h1010, 4'd4);

    // async reset in the middle of a hold, button kept high
    lap_btn = 1'b1;
    run_cycles(6, 16'h0d00, 16'h0000, 1'b0);
    live_value = 16'h0444;
    exp_cnt = 4'd5;
    step();
    chk("pre_rst_display", display_value, 16'h0444);
    run_cycles(3, 16'h0d10, 16'h0444, 1'b1);
    #3;
    reset = 1'b1;
    #1;
    chk("async_display", display_value, 16'h0000);
    chk("async_holding", {15'd0, holding}, 16'd0);
    chk("async_count", {12'd0, lap_count}, 16'd0);
    exp_cnt = 4'd0;
    step();
    step();
    reset = 1'b0;
    run_cycles(6, 16'h0e00, 16'h0000, 1'b0);
    run = 1'b0;
    run_cycles(4, 16'h0e10, 16'h0000, 1'b0);
    lap_btn = 1'b0;
    run_cycles(8, 16'h0e20, 16'h0000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
